ecdsa_lh_writer: RTL and testbench

// ECDSA-side endpoint of the logic-hash interface. Receives the type1 packet stream and the per-packet

---
 rtl/ecdsa_lh_writer_if.sv | 73 +++++++
 rtl/ecdsa_lh_writer.sv | 231 +++++++++++++++++++++++
 tb/tb_ecdsa_lh_writer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecdsa_lh_writer_if.sv
// Shared types and the bundled signal interface between logic_hash, the
// ECDSA verify core and the ecdsa_lh_writer endpoint.

package ecdsa_lh_pkg;

  localparam int META_FID_NBITS = 12;

  // Per-word metadata delivered alongside the packet stream; only the
  // flow id is consumed by the writer (on the first word of a packet).
  typedef struct packed {
    logic [META_FID_NBITS-1:0] fid;
  } lh_ecdsa_meta_type;

endpackage

interface ecdsa_lh_writer_if #(
  parameter int FID_NBITS        = ecdsa_lh_pkg::META_FID_NBITS,
  parameter int LOGIC_HASH_NBITS = 256,
  parameter int SERIAL_NUM_NBITS = 32,
  parameter int PPL_NBITS        = 2
);

  // Packet stream and generated hash from logic_hash
  logic                              lh_ecdsa_valid;
  logic [127:0]                      lh_ecdsa_hdr_data;
  ecdsa_lh_pkg::lh_ecdsa_meta_type   lh_ecdsa_meta_data;
  logic                              lh_ecdsa_sop;
  logic                              lh_ecdsa_eop;
  logic                              lh_ecdsa_hash_valid;
  logic [LOGIC_HASH_NBITS-1:0]       lh_ecdsa_hash_data;
  logic                              ecdsa_lh_ready;

  // Verify request/response with the ECDSA core
  logic                              ecdsa_req_valid;
  logic                              ecdsa_req_ready;
  logic [FID_NBITS-1:0]              ecdsa_req_fid;
  logic [LOGIC_HASH_NBITS-1:0]       ecdsa_req_hash;
  logic                              ecdsa_resp_valid;
  logic                              ecdsa_resp_pass;

  // Table update written back into logic_hash
  logic                              ecdsa_lh_wr;
  logic [FID_NBITS-1:0]              ecdsa_lh_waddr;
  logic [LOGIC_HASH_NBITS-1:0]       ecdsa_lh_wdata;
  logic [SERIAL_NUM_NBITS-1:0]       ecdsa_lh_sn_wdata;
  logic [PPL_NBITS-1:0]              ecdsa_lh_ppl_wdata;

  // Statistics
  logic [31:0]                       pass_cnt;
  logic [31:0]                       fail_cnt;
  logic [31:0]                       ovf_cnt;

  // The writer endpoint
  modport slave (
    input  lh_ecdsa_valid, lh_ecdsa_hdr_data, lh_ecdsa_meta_data,
           lh_ecdsa_sop, lh_ecdsa_eop, lh_ecdsa_hash_valid, lh_ecdsa_hash_data,
           ecdsa_req_ready, ecdsa_resp_valid, ecdsa_resp_pass,
    output ecdsa_lh_ready, ecdsa_req_valid, ecdsa_req_fid, ecdsa_req_hash,
           ecdsa_lh_wr, ecdsa_lh_waddr, ecdsa_lh_wdata, ecdsa_lh_sn_wdata,
           ecdsa_lh_ppl_wdata, pass_cnt, fail_cnt, ovf_cnt
  );

  // The environment: logic_hash plus the ECDSA core
  modport master (
    output lh_ecdsa_valid, lh_ecdsa_hdr_data, lh_ecdsa_meta_data,
           lh_ecdsa_sop, lh_ecdsa_eop, lh_ecdsa_hash_valid, lh_ecdsa_hash_data,
           ecdsa_req_ready, ecdsa_resp_valid, ecdsa_resp_pass,
    input  ecdsa_lh_ready, ecdsa_req_valid, ecdsa_req_fid, ecdsa_req_hash,
           ecdsa_lh_wr, ecdsa_lh_waddr, ecdsa_lh_wdata, ecdsa_lh_sn_wdata,
           ecdsa_lh_ppl_wdata, pass_cnt, fail_cnt, ovf_cnt
  );

endinterface

// File: rtl/ecdsa_lh_writer.sv
// ECDSA-side endpoint of the logic-hash interface. Pairs each type1 packet
// with its logic hash, queues {fid, hash, sn, ppl} contexts in a small FIFO,
// runs one verify request at a time against the ECDSA core and writes the
// context back into the logic_hash table when the signature checks out.

module ecdsa_lh_writer #(
  parameter int FID_NBITS        = 12,
  parameter int LOGIC_HASH_NBITS = 256,
  parameter int SERIAL_NUM_NBITS = 32,
  parameter int PPL_NBITS        = 2,
  parameter int SN_POS           = 127,
  parameter int PPL_POS          = 95,
  parameter int CTX_DEPTH_NBITS  = 3
) (
  input  logic              clk,
  input  logic              rst,
  ecdsa_lh_writer_if.slave  bus
);

  localparam int DEPTH = 1 << CTX_DEPTH_NBITS;
  localparam int CNT_W = CTX_DEPTH_NBITS + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE
  } state_t;

  // Packet capture state
  logic                         in_pkt;
  logic                         hash_ok;
  logic [FID_NBITS-1:0]         cap_fid;
  logic [LOGIC_HASH_NBITS-1:0]  cap_hash;
  logic [SERIAL_NUM_NBITS-1:0]  cap_sn;
  logic [PPL_NBITS-1:0]         cap_ppl;

  // Context FIFO
  logic [FID_NBITS-1:0]         mem_fid  [DEPTH];
  logic [LOGIC_HASH_NBITS-1:0]  mem_hash [DEPTH];
  logic [SERIAL_NUM_NBITS-1:0]  mem_sn   [DEPTH];
  logic [PPL_NBITS-1:0]         mem_ppl  [DEPTH];
  logic [CTX_DEPTH_NBITS-1:0]   wr_ptr;
  logic [CTX_DEPTH_NBITS-1:0]   rd_ptr;
  logic [CNT_W-1:0]             count;
  logic [CNT_W-1:0]             next_count;
  logic                         ready_q;
  logic                         ready_next;
  logic [31:0]                  ovf_q;

  // Push-side decode
  logic                         sop_beat;
  logic                         push_req;
  logic                         push_ok;
  logic                         ovf;
  logic                         pop;
  logic                         full;
  logic [FID_NBITS-1:0]         push_fid;
  logic [LOGIC_HASH_NBITS-1:0]  push_hash;
  logic [SERIAL_NUM_NBITS-1:0]  push_sn;
  logic [PPL_NBITS-1:0]         push_ppl;

  // Verify sequencer
  state_t                       state;
  logic                         req_valid_q;
  logic [FID_NBITS-1:0]         req_fid_q;
  logic [LOGIC_HASH_NBITS-1:0]  req_hash_q;
  logic [SERIAL_NUM_NBITS-1:0]  ctx_sn;
  logic [PPL_NBITS-1:0]         ctx_ppl;
  logic                         wr_q;
  logic [FID_NBITS-1:0]         waddr_q;
  logic [LOGIC_HASH_NBITS-1:0]  wdata_q;
  logic [SERIAL_NUM_NBITS-1:0]  sn_wdata_q;
  logic [PPL_NBITS-1:0]         ppl_wdata_q;
  logic [31:0]                  pass_q;
  logic [31:0]                  fail_q;

  // Decide whether this beat completes a pushable packet. A single-word packet
  // bypasses the capture registers so it can be pushed in the cycle it arrives;
  // a pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  always_comb begin
    sop_beat   = bus.lh_ecdsa_valid & bus.lh_ecdsa_sop;
    push_req   = bus.lh_ecdsa_valid & bus.lh_ecdsa_eop &
                 (bus.lh_ecdsa_sop ? bus.lh_ecdsa_hash_valid : (in_pkt & hash_ok));
    push_fid   = bus.lh_ecdsa_sop ? bus.lh_ecdsa_meta_data.fid : cap_fid;
    push_hash  = bus.lh_ecdsa_sop ? bus.lh_ecdsa_hash_data : cap_hash;
    push_sn    = bus.lh_ecdsa_sop ? bus.lh_ecdsa_hdr_data[SN_POS -: SERIAL_NUM_NBITS] : cap_sn;
    push_ppl   = bus.lh_ecdsa_sop ? bus.lh_ecdsa_hdr_data[PPL_POS -: PPL_NBITS] : cap_ppl;
    full       = (count == CNT_W'(DEPTH));
    pop        = (state == S_IDLE) && (count != '0);
    push_ok    = push_req & (~full | pop);
    ovf        = push_req & full & ~pop;
    next_count = count + {{CTX_DEPTH_NBITS{1'b0}}, push_ok} - {{CTX_DEPTH_NBITS{1'b0}}, pop};
    ready_next = (next_count <= CNT_W'(DEPTH - 2));
  end

  // Track the packet in progress: latch header fields on sop, remember whether the hash arrived with it
  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt   <= 1'b0;
      hash_ok  <= 1'b0;
      cap_fid  <= '0;
      cap_hash <= '0;
      cap_sn   <= '0;
      cap_ppl  <= '0;
    end else if (sop_beat) begin
      cap_fid <= bus.lh_ecdsa_meta_data.fid;
      cap_sn  <= bus.lh_ecdsa_hdr_data[SN_POS -: SERIAL_NUM_NBITS];
      cap_ppl <= bus.lh_ecdsa_hdr_data[PPL_POS -: PPL_NBITS];
      hash_ok <= bus.lh_ecdsa_hash_valid;
      if (bus.lh_ecdsa_hash_valid) begin
        cap_hash <= bus.lh_ecdsa_hash_data;
      end
      in_pkt <= ~bus.lh_ecdsa_eop;
    end else if (bus.lh_ecdsa_valid && bus.lh_ecdsa_eop) begin
      in_pkt <= 1'b0;
    end
  end

  // Context storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_fid[wr_ptr]  <= push_fid;
      mem_hash[wr_ptr] <= push_hash;
      mem_sn[wr_ptr]   <= push_sn;
      mem_ppl[wr_ptr]  <= push_ppl;
    end
  end

  // FIFO pointers, occupancy, registered ready and the overflow statistic
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
      ovf_q   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + CTX_DEPTH_NBITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CTX_DEPTH_NBITS'(1);
      end
      count   <= next_count;
      ready_q <= ready_next;
      if (ovf && (ovf_q != 32'hFFFF_FFFF)) begin
        ovf_q <= ovf_q + 32'd1;
      end
    end
  end

  // Verify sequencer: pop a context, hold the request until accepted, await the verdict, write back on pass
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      req_valid_q <= 1'b0;
      req_fid_q   <= '0;
      req_hash_q  <= '0;
      ctx_sn      <= '0;
      ctx_ppl     <= '0;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      sn_wdata_q  <= '0;
      ppl_wdata_q <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
    end else begin
      wr_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            req_fid_q   <= mem_fid[rd_ptr];
            req_hash_q  <= mem_hash[rd_ptr];
            ctx_sn      <= mem_sn[rd_ptr];
            ctx_ppl     <= mem_ppl[rd_ptr];
            req_valid_q <= 1'b1;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.ecdsa_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.ecdsa_resp_valid) begin
            if (bus.ecdsa_resp_pass) begin
              wr_q        <= 1'b1;
              waddr_q     <= req_fid_q;
              wdata_q     <= req_hash_q;
              sn_wdata_q  <= ctx_sn;
              ppl_wdata_q <= ctx_ppl;
              if (pass_q != 32'hFFFF_FFFF) begin
                pass_q <= pass_q + 32'd1;
              end
              state <= S_WRITE;
            end else begin
              if (fail_q != 32'hFFFF_FFFF) begin
                fail_q <= fail_q + 32'd1;
              end
              state <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ecdsa_lh_ready     = ready_q;
  assign bus.ecdsa_req_valid    = req_valid_q;
  assign bus.ecdsa_req_fid      = req_fid_q;
  assign bus.ecdsa_req_hash     = req_hash_q;
  assign bus.ecdsa_lh_wr        = wr_q;
  assign bus.ecdsa_lh_waddr     = waddr_q;
  assign bus.ecdsa_lh_wdata     = wdata_q;
  assign bus.ecdsa_lh_sn_wdata  = sn_wdata_q;
  assign bus.ecdsa_lh_ppl_wdata = ppl_wdata_q;
  assign bus.pass_cnt           = pass_q;
  assign bus.fail_cnt           = fail_q;
  assign bus.ovf_cnt            = ovf_q;

endmodule

// File: tb/tb_ecdsa_lh_writer.sv
// Directed-plus-random bench for ecdsa_lh_writer. A transaction-level model
// (a queue of expected verify contexts, an occupancy figure and expected
// statistics) predicts every request and every table write.

module tb_ecdsa_lh_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ecdsa_lh_writer_if bus ();

  ecdsa_lh_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]  fid;
    logic [255:0] hash;
    logic [31:0]  sn;
    logic [1:0]   ppl;
  } ctx_t;

  ctx_t exp_q[$];
  int   occ       = 0;
  bit   inflight  = 0;
  int   exp_pass  = 0;
  int   exp_fail  = 0;
  int   exp_ovf   = 0;
  int   checks    = 0;
  int   passed    = 0;

  // Hard stop in case the sequence ever stalls outside a bounded wait
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic idle_inputs();
    bus.lh_ecdsa_valid      = 1'b0;
    bus.lh_ecdsa_sop        = 1'b0;
    bus.lh_ecdsa_eop        = 1'b0;
    bus.lh_ecdsa_hdr_data   = '0;
    bus.lh_ecdsa_meta_data  = '0;
    bus.lh_ecdsa_hash_valid = 1'b0;
    bus.lh_ecdsa_hash_data  = '0;
    bus.ecdsa_resp_valid    = 1'b0;
    bus.ecdsa_resp_pass     = 1'b0;
  endtask

  function automatic logic [255:0] rand_hash();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] make_hdr(input logic [31:0] sn, input logic [1:0] ppl);
    logic [127:0] h;
    h          = {$urandom, $urandom, $urandom, $urandom};
    h[127:96]  = sn;
    h[95:94]   = ppl;
    return h;
  endfunction

  // Drive one packet word for one clock, then release the stream
  task automatic apply_stimulus(input bit sop, input bit eop, input logic [11:0] fid,
                                input logic [127:0] hdr, input bit hv, input logic [255:0] hash);
    bus.lh_ecdsa_valid          = 1'b1;
    bus.lh_ecdsa_sop            = sop;
    bus.lh_ecdsa_eop            = eop;
    bus.lh_ecdsa_meta_data.fid  = fid;
    bus.lh_ecdsa_hdr_data       = hdr;
    bus.lh_ecdsa_hash_valid     = hv;
    bus.lh_ecdsa_hash_data      = hash;
    @(negedge clk);
    bus.lh_ecdsa_valid      = 1'b0;
    bus.lh_ecdsa_sop        = 1'b0;
    bus.lh_ecdsa_eop        = 1'b0;
    bus.lh_ecdsa_hash_valid = 1'b0;
  endtask

  task automatic model_push(input logic [11:0] fid, input logic [255:0] hash,
                            input logic [31:0] sn, input logic [1:0] ppl);
    ctx_t c;
    c.fid = fid; c.hash = hash; c.sn = sn; c.ppl = ppl;
    if (occ < 8) begin
      exp_q.push_back(c);
      occ++;
    end else begin
      exp_ovf++;
    end
  endtask

  task automatic send_pkt(input logic [11:0] fid, input logic [31:0] sn, input logic [1:0] ppl,
                          input logic [255:0] hash, input int nwords, input bit with_hash);
    for (int w = 0; w < nwords; w++) begin
      if (w == 0)
        apply_stimulus(1'b1, nwords == 1, fid, make_hdr(sn, ppl), with_hash, hash);
      else
        apply_stimulus(1'b0, w == nwords - 1, 12'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    end
    if (with_hash) model_push(fid, hash, sn, ppl);
  endtask

  task automatic wait_req();
    int i;
    i = 0;
    while (!bus.ecdsa_req_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    check_output("req_seen", bus.ecdsa_req_valid, 1'b1);
    if (bus.ecdsa_req_valid && !inflight) begin
      inflight = 1'b1;
      occ--;
    end
  endtask

  // Serve one verify request: check it against the model, answer after 'delay' cycles, check the write-back
  task automatic serve_one(input bit pass, input int delay);
    ctx_t c;
    wait_req();
    check_output("req_expected", exp_q.size() != 0, 1'b1);
    if (!bus.ecdsa_req_valid || exp_q.size() == 0) return;
    c = exp_q.pop_front();
    check_output("req_fid", bus.ecdsa_req_fid, c.fid);
    check_output("req_hash", bus.ecdsa_req_hash, c.hash);
    @(negedge clk);
    check_output("req_dropped", bus.ecdsa_req_valid, 1'b0);
    repeat (delay) @(negedge clk);
    bus.ecdsa_resp_valid = 1'b1;
    bus.ecdsa_resp_pass  = pass;
    @(negedge clk);
    bus.ecdsa_resp_valid = 1'b0;
    bus.ecdsa_resp_pass  = 1'b0;
    inflight = 1'b0;
    check_output("wr_pulse", bus.ecdsa_lh_wr, pass);
    check_output("wr_no_req", bus.ecdsa_lh_wr & bus.ecdsa_req_valid, 1'b0);
    if (pass) begin
      exp_pass++;
      check_output("waddr", bus.ecdsa_lh_waddr, c.fid);
      check_output("wdata", bus.ecdsa_lh_wdata, c.hash);
      check_output("sn_wdata", bus.ecdsa_lh_sn_wdata, c.sn);
      check_output("ppl_wdata", bus.ecdsa_lh_ppl_wdata, c.ppl);
    end else begin
      exp_fail++;
    end
    @(negedge clk);
    check_output("wr_one_cycle", bus.ecdsa_lh_wr, 1'b0);
  endtask

  task automatic expect_no_req(input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen |= bus.ecdsa_req_valid;
    end
    check_output("no_req", seen, 1'b0);
  endtask

  task automatic check_counters(input string tag);
    check_output({tag, "_pass_cnt"}, bus.pass_cnt, exp_pass);
    check_output({tag, "_fail_cnt"}, bus.fail_cnt, exp_fail);
    check_output({tag, "_ovf_cnt"}, bus.ovf_cnt, exp_ovf);
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ      = 0;
    inflight = 1'b0;
    exp_pass = 0;
    exp_fail = 0;
    exp_ovf  = 0;
  endtask

  // Directed scenarios followed by a randomized packet mix
  initial begin
    logic [255:0] h;
    logic [11:0]  fid_a;
    logic [11:0]  fid_b;
    logic [31:0]  sn_b;
    logic [1:0]   ppl_b;
    bit           pass;
    bit           with_hash;

    idle_inputs();
    bus.ecdsa_req_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    check_output("rst_ready", bus.ecdsa_lh_ready, 1'b1);
    check_output("rst_req_valid", bus.ecdsa_req_valid, 1'b0);
    check_output("rst_wr", bus.ecdsa_lh_wr, 1'b0);
    check_output("rst_waddr", bus.ecdsa_lh_waddr, '0);
    check_output("rst_wdata", bus.ecdsa_lh_wdata, '0);
    check_counters("rst");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] T1 passing verify");
    h = rand_hash();
    send_pkt(12'h012, 32'h0000_0005, 2'd2, h, 3, 1'b1);
    serve_one(1'b1, 4);
    check_counters("t1");

    $display("[TB] T2 failing verify");
    send_pkt(12'h012, 32'h0000_0005, 2'd2, h, 3, 1'b1);
    serve_one(1'b0, 4);
    check_counters("t2");
    expect_no_req(5);

    $display("[TB] T3 unpaired hashes and sop without hash");
    repeat (3) begin
      bus.lh_ecdsa_hash_valid = 1'b1;
      bus.lh_ecdsa_hash_data  = rand_hash();
      @(negedge clk);
    end
    bus.lh_ecdsa_hash_valid = 1'b0;
    send_pkt(12'($urandom), $urandom, 2'($urandom), rand_hash(), 2, 1'b0);
    expect_no_req(8);
    send_pkt(12'($urandom), $urandom, 2'($urandom), rand_hash(), 3, 1'b1);
    serve_one(1'b1, 2);
    check_counters("t3");

    $display("[TB] T4 backpressure and overflow");
    bus.ecdsa_req_ready = 1'b0;
    send_pkt(12'($urandom), $urandom, 2'($urandom), rand_hash(), 1, 1'b1);
    wait_req();
    for (int k = 1; k <= 9; k++) begin
      fid_a = 12'($urandom);
      sn_b  = $urandom;
      ppl_b = 2'($urandom);
      h     = rand_hash();
      apply_stimulus(1'b1, 1'b1, fid_a, make_hdr(sn_b, ppl_b), 1'b1, h);
      model_push(fid_a, h, sn_b, ppl_b);
      check_output($sformatf("ready_after_push%0d", k), bus.ecdsa_lh_ready, occ <= 6);
    end
    check_counters("t4_ovf");
    bus.ecdsa_req_ready = 1'b1;
    for (int k = 0; k < 9; k++) serve_one(1'b1, int'($urandom_range(0, 3)));
    check_counters("t4");
    expect_no_req(6);

    $display("[TB] T5 reset in WAIT and mid-packet");
    send_pkt(12'($urandom), $urandom, 2'($urandom), rand_hash(), 2, 1'b1);
    wait_req();
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 12'($urandom), make_hdr($urandom, 2'($urandom)), 1'b1, rand_hash());
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_output("t5_wr", bus.ecdsa_lh_wr, 1'b0);
    check_output("t5_req_valid", bus.ecdsa_req_valid, 1'b0);
    check_output("t5_req_hash", bus.ecdsa_req_hash, '0);
    check_output("t5_ready", bus.ecdsa_lh_ready, 1'b1);
    check_counters("t5_rst");
    bus.ecdsa_resp_valid = 1'b1;
    bus.ecdsa_resp_pass  = 1'b1;
    @(negedge clk);
    bus.ecdsa_resp_valid = 1'b0;
    bus.ecdsa_resp_pass  = 1'b0;
    apply_stimulus(1'b0, 1'b1, 12'($urandom), '0, 1'b0, '0);
    check_output("t5_stray_resp_wr", bus.ecdsa_lh_wr, 1'b0);
    expect_no_req(6);
    send_pkt(12'($urandom), $urandom, 2'($urandom), rand_hash(), 3, 1'b1);
    serve_one(1'b1, 1);
    check_counters("t5");

    $display("[TB] T6 restarted capture and stray eop");
    fid_a = 12'h0A5;
    fid_b = 12'h35B;
    sn_b  = $urandom;
    ppl_b = 2'($urandom);
    h     = rand_hash();
    apply_stimulus(1'b1, 1'b0, fid_a, make_hdr($urandom, 2'($urandom)), 1'b1, rand_hash());
    apply_stimulus(1'b0, 1'b0, 12'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    apply_stimulus(1'b1, 1'b0, fid_b, make_hdr(sn_b, ppl_b), 1'b1, h);
    apply_stimulus(1'b0, 1'b1, 12'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    model_push(fid_b, h, sn_b, ppl_b);
    apply_stimulus(1'b0, 1'b1, 12'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    serve_one(1'b1, 1);
    expect_no_req(8);
    check_counters("t6");

    $display("[TB] random packet mix");
    for (int n = 0; n < 16; n++) begin
      with_hash = ($urandom_range(0, 3) != 0);
      pass      = 1'($urandom_range(0, 1));
      send_pkt(12'($urandom), $urandom, 2'($urandom), rand_hash(),
               int'($urandom_range(1, 4)), with_hash);
      if (with_hash) serve_one(pass, int'($urandom_range(0, 5)));
      else expect_no_req(6);
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
    check_counters("rand");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
